// File: rtl/aes_pkg.sv
// Shared constants and helper functions for the iterative AES-128 inverse key schedule.
package aes_pkg;

  localparam int AES_NR = 10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_SERVE  = 2'd2;

  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] val;
    case (round)
      4'd1:    val = 8'h01;
      4'd2:    val = 8'h02;
      4'd3:    val = 8'h04;
      4'd4:    val = 8'h08;
      4'd5:    val = 8'h10;
      4'd6:    val = 8'h20;
      4'd7:    val = 8'h40;
      4'd8:    val = 8'h80;
      4'd9:    val = 8'h1b;
      4'd10:   val = 8'h36;
      default: val = 8'h00;
    endcase
    return val;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      s = gf_xtime(s);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(a, a);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    logic [15:0] d;
    d = {a, a} << n;
    return d[15:8];
  endfunction

endpackage

// File: rtl/aes_inv_key_schedule_if.sv
// Bus between the key schedule and its controller/consumer; clock and reset stay plain ports.
interface aes_inv_key_schedule_if;
  logic         i_Start;
  logic         i_Mode;
  logic [127:0] i_Key;
  logic [127:0] o_RoundKey;
  logic [3:0]   o_Round;
  logic         o_Valid;
  logic         i_Ready;
  logic         o_Busy;
  logic         o_Done;
  logic [1:0]   dbg_state;

  // Handshake: a key transfers on a rising edge where o_Valid && i_Ready; while o_Valid is
  // high and i_Ready is low, o_RoundKey and o_Round hold. o_Valid never drops without a transfer.
  modport slave (
    input  i_Start, i_Mode, i_Key, i_Ready,
    output o_RoundKey, o_Round, o_Valid, o_Busy, o_Done, dbg_state
  );

  modport master (
    output i_Start, i_Mode, i_Key, i_Ready,
    input  o_RoundKey, o_Round, o_Valid, o_Busy, o_Done, dbg_state
  );
endinterface

// File: rtl/aes_sbox.sv
// AES S-box computed from GF(2^8) inversion plus affine map; i_fEnc=1 forward, 0 inverse.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_Data,
  input  logic       i_fEnc,
  output logic [7:0] o_Data
);

  logic [7:0] fwd;
  logic [7:0] inv_aff;
  logic [7:0] inv;

  always_comb begin
    fwd = gf_inv(i_Data);
    fwd = fwd ^ rotl8(fwd, 1) ^ rotl8(fwd, 2) ^ rotl8(fwd, 3) ^ rotl8(fwd, 4) ^ 8'h63;
    inv_aff = rotl8(i_Data, 1) ^ rotl8(i_Data, 3) ^ rotl8(i_Data, 6) ^ 8'h05;
    inv = gf_inv(inv_aff);
  end

  assign o_Data = i_fEnc ? fwd : inv;

endmodule

// File: rtl/aes_sub_word.sv
// SubWord: forward S-box applied to each byte of a 32-bit word, purely combinational.
module aes_sub_word (
  input  logic [31:0] i_Word,
  output logic [31:0] o_Word
);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .i_Data (i_Word[8*b +: 8]),
      .i_fEnc (1'b1),
      .o_Data (o_Word[8*b +: 8])
    );
  end

endmodule

// File: rtl/aes_inv_key_schedule.sv
// Iterative AES-128 key schedule delivering round keys 10 down to 0 over a valid/ready port.
module aes_inv_key_schedule
  import aes_pkg::*;
(
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  aes_inv_key_schedule_if.slave bus
);

  localparam logic [3:0] LAST_ROUND = 4'(AES_NR);

  logic [1:0]   state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  w3p, w2p, w1p, w0p;
  logic [31:0]  t_fwd0, t_fwd1, t_fwd2, t_fwd3;
  logic [31:0]  sub_in, sub_out;
  logic [31:0]  rcon_word;
  logic [127:0] fwd_key, inv_key;

  assign {w0, w1, w2, w3} = key_q;
  assign rcon_word = {rcon(round_q), 24'h0};

  // Backward step recovers w1..w3 by XOR alone; only w0 needs SubWord, of the recovered w3.
  assign w3p = w3 ^ w2;
  assign w2p = w2 ^ w1;
  assign w1p = w1 ^ w0;

  // One SubWord shared by both directions: w3 while expanding, w3p while serving.
  assign sub_in = (state_q == ST_EXPAND) ? rot_word(w3) : rot_word(w3p);

  aes_sub_word u_sub_word (
    .i_Word (sub_in),
    .o_Word (sub_out)
  );

  assign t_fwd0  = w0 ^ sub_out ^ rcon_word;
  assign t_fwd1  = w1 ^ t_fwd0;
  assign t_fwd2  = w2 ^ t_fwd1;
  assign t_fwd3  = w3 ^ t_fwd2;
  assign fwd_key = {t_fwd0, t_fwd1, t_fwd2, t_fwd3};

  assign w0p     = w0 ^ sub_out ^ rcon_word;
  assign inv_key = {w0p, w1p, w2p, w3p};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A start coinciding with the done pulse is dropped so the consumer sees a clean gap.
        if (bus.i_Start && !done_q) begin
          key_d = bus.i_Key;
          if (bus.i_Mode) begin
            round_d = LAST_ROUND;
            valid_d = 1'b1;
            state_d = ST_SERVE;
          end else begin
            round_d = 4'd1;
            state_d = ST_EXPAND;
          end
        end
      end
      ST_EXPAND: begin
        key_d = fwd_key;
        if (round_q == LAST_ROUND) begin
          valid_d = 1'b1;
          state_d = ST_SERVE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      ST_SERVE: begin
        if (valid_q && bus.i_Ready) begin
          if (round_q != 4'd0) begin
            key_d   = inv_key;
            round_d = round_q - 4'd1;
          end else begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_RoundKey = key_q;
  assign bus.o_Round    = round_q;
  assign bus.o_Valid    = valid_q;
  assign bus.o_Busy     = (state_q != ST_IDLE);
  assign bus.o_Done     = done_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: doc/aes_inv_key_schedule.md
Name: aes_inv_key_schedule

Overview:
- Iterative AES-128 key schedule that supplies round keys in descending order (round 10 down to round 0) for the decryption datapath.
- Takes either the cipher key, which it expands forward internally, or the final round key directly.
- Steps the schedule backward one round per accepted key; the inverse cipher consumes keys through a valid/ready handshake.
- Word S-box lookups use the existing forward S-box with fEnc tied to 1.

Parameters:
- NR, 10, number of AES rounds; fixed for AES-128, not overridable.

Ports:
- i_Clk  input  1  clock; all state updates on the rising edge.
- i_Rst_n  input  1  reset, asynchronous, active-low.
- i_Start  input  1  one-cycle request to begin a schedule; sampled in IDLE only.
- i_Mode  input  1  0 = i_Key is the cipher key (expand first); 1 = i_Key is the round-10 key.
- i_Key  input  128  key, big-endian: w0 = [127:96], byte 0 = [127:120].
- o_RoundKey  output  128  current round key, same byte order as i_Key.
- o_Round  output  4  round index of o_RoundKey (10..0).
- o_Valid  output  1  o_RoundKey/o_Round valid.
- i_Ready  input  1  consumer accepts the key when o_Valid && i_Ready.
- o_Busy  output  1  high in any state other than IDLE.
- o_Done  output  1  one-cycle pulse after round 0 is accepted.

Behaviour:
- Reset (asynchronous, any state): state = IDLE; key register, o_RoundKey, o_Round, o_Valid, o_Busy, o_Done all 0.
- States: IDLE, EXPAND, SERVE.
- IDLE:
  - i_Start with i_Mode=0: load i_Key, round counter = 1, go to EXPAND.
  - i_Start with i_Mode=1: load i_Key, o_Round = 10, go to SERVE.
- EXPAND: one forward step per cycle for r = 1..10.
  - Forward step: t = SubWord(RotWord(w3)) ^ {Rcon[r], 24'h0}; w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - RotWord(w) = {w[23:0], w[31:24]}; SubWord = S-box applied to each byte.
  - After r = 10: go to SERVE with o_Round = 10.
  - Total: 10 EXPAND cycles; o_Valid rises on the 11th edge after the i_Start edge.
- SERVE:
  - o_Valid = 1; o_RoundKey and o_Round are held stable while i_Ready = 0.
  - On acceptance with o_Round = k > 0: apply the inverse step using Rcon[k]; o_Round = k-1; o_Valid stays 1, so back-to-back acceptance yields one key per cycle.
  - Inverse step from (w0..w3) of round k: w3p = w3 ^ w2; w2p = w2 ^ w1; w1p = w1 ^ w0; w0p = w0 ^ SubWord(RotWord(w3p)) ^ {Rcon[k], 24'h0}.
  - On acceptance with o_Round = 0: o_Valid = 0, o_Done = 1 for one cycle, go to IDLE.
- Rcon[1..10]: 01 02 04 08 10 20 40 80 1b 36, as a constant table indexed by the round counter.
- i_Start outside IDLE is ignored. i_Start in the same cycle as the o_Done pulse is ignored; a new start is accepted from the next cycle.
- i_Key and i_Mode are sampled only on the i_Start cycle; later changes have no effect.
- One shared SubWord instance feeds both steps. Its input is muxed: w3 in EXPAND, w3p in SERVE. It sits on the combinational path; the only registers are the 128-bit key, counter, state and outputs.
- o_Busy = (state != IDLE); o_Busy deasserts in the same cycle o_Done pulses.

Decomposition:
- Package aes_pkg:
  - constant AES_NR = 10;
  - Rcon table function rcon(round[3:0]) -> [7:0];
  - rot_word function;
  - state encoding constants ST_IDLE, ST_EXPAND, ST_SERVE.
- Sub-module aes_sub_word: 32-bit in/out, four S-box instances with fEnc = 1, purely combinational.

Test Plan:
- FIPS-197 key, mode 0:
  - i_Key = 2b7e151628aed2a6abf7158809cf4f3c, i_Start, i_Ready = 1 -> o_Valid after 11 cycles.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, round 1 = a0fafe1788542cb123a339392a6c7605, round 0 = i_Key.
  - o_Done pulses once after round 0; 11 keys on consecutive cycles.
- Mode 1: i_Key = d014f9a8c9ee2589e13f0cc8b6630ca6 -> o_Valid the next cycle with o_Round = 10; sequence ends at 2b7e151628aed2a6abf7158809cf4f3c.
- Backpressure: i_Ready low for 5 cycles at o_Round = 7 -> o_RoundKey and o_Round unchanged; resumes at round 6 on the first acceptance.
- i_Start pulsed during EXPAND and during SERVE -> ignored, the key sequence is unchanged; i_Start on the o_Done cycle -> ignored.
- i_Rst_n low mid-SERVE (o_Round = 4), asynchronous to the clock -> outputs 0 immediately; a fresh mode-0 run afterwards reproduces the full FIPS sequence.
- All-zero key, mode 0 -> round 10 = b4ef5bcb3e92e21123e951cf6f8f188e; the backward walk returns 00..00 at round 0.
